weight_read_seq: RTL



---
 rtl/weight_read_seq.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/weight_read_seq.sv
// weight_read_seq
// Read-side sequencer for the per-PE weight scratch pad. For each of P
// output pixels it replays the pad's W stored weights in order, and hands
// each word to the MAC datapath through a valid/ready handshake.
//
// How a word moves through the block:
//   issue (cycle c0)    -> raddra_filter is registered at the end of c0
//   pad read (c1)       -> the RAM registers its output at the end of c1
//   capture (c2)        -> weight_out is pushed into the output buffer
//   present (c3)        -> w_valid is high
// Words in the tag pipe are counted as "inflight". Issue is allowed only
// while inflight plus buffer occupancy is below OUT_DEPTH, so every read
// already has a buffer slot reserved. MAC back-pressure therefore never
// drops a word.
//
// Ports:
//   clk, rst                  clock; asynchronous active-low reset
//   start, weight_num (W),    job request; W and P are sampled on an
//   pixel_num (P)             accepted start (accepted only while idle)
//   pad_data_ready,           issue gate from the pad loader
//   weight_loaded
//   weight_out                pad read data (1-cycle synchronous read)
//   raddra_filter             registered pad read address
//   base_address              address of the next read to issue
//   w_valid, w_data,          output word and its flags, held stable
//   w_last_px, w_last         while w_valid & !mac_ready
//   mac_ready                 consumer ready
//   busy, done                job active; 1-cycle pulse at completion
module weight_read_seq #(
  parameter int DATA_WIDTH         = 16,
  parameter int ADDRESSWIDTH_W_PAD = 8,
  parameter int ADDRESSWIDTH_F_PAD = 8,
  parameter int OUT_DEPTH          = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [ADDRESSWIDTH_W_PAD-1:0] weight_num,
  input  logic [ADDRESSWIDTH_F_PAD-1:0] pixel_num,
  input  logic                          pad_data_ready,
  input  logic                          weight_loaded,
  input  logic [DATA_WIDTH-1:0]         weight_out,
  output logic [ADDRESSWIDTH_W_PAD-1:0] raddra_filter,
  output logic [ADDRESSWIDTH_W_PAD-1:0] base_address,
  output logic                          w_valid,
  output logic [DATA_WIDTH-1:0]         w_data,
  output logic                          w_last_px,
  output logic                          w_last,
  input  logic                          mac_ready,
  output logic                          busy,
  output logic                          done
);

  localparam int AW     = ADDRESSWIDTH_W_PAD;
  localparam int FW     = ADDRESSWIDTH_F_PAD;
  localparam int PTR_W  = $clog2(OUT_DEPTH);
  localparam int CNT_W  = $clog2(OUT_DEPTH + 1);
  localparam int SUM_W  = CNT_W + 1;
  // vld_pipe[0]: address is on the pad port; vld_pipe[STAGES]: weight_out is valid
  localparam int STAGES = 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  typedef struct packed {
    logic last_px;
    logic last;
  } tag_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  last_px;
    logic                  last;
  } ent_t;

  state_t                    state, state_nxt;
  logic [AW-1:0]             w_num_q, nxt_addr;
  logic [FW-1:0]             p_num_q, px_cnt;
  logic [STAGES:0]           vld_pipe;
  tag_t [STAGES:0]           tag_pipe;
  ent_t [OUT_DEPTH-1:0]      buf_mem;
  logic [PTR_W-1:0]          wr_ptr, rd_ptr;
  logic [CNT_W-1:0]          occ, occ_nxt;
  logic [1:0]                inflight;
  logic                      gate, credit, at_w_end, at_p_end;
  logic                      accept, degenerate, issue, drain_done;
  logic                      push, pop;
  ent_t                      head;

  assign base_address = nxt_addr;

  assign inflight = 2'(vld_pipe[0]) + 2'(vld_pipe[1]);
  assign gate     = pad_data_ready | weight_loaded;
  // Credits come from the registered occupancy, so a pop in this cycle
  // frees its slot only from the next cycle on.
  assign credit   = (SUM_W'(occ) + SUM_W'(inflight)) < SUM_W'(OUT_DEPTH);
  assign at_w_end = (nxt_addr == (w_num_q - 1'b1));
  assign at_p_end = (px_cnt == (p_num_q - 1'b1));

  assign push    = vld_pipe[STAGES];
  assign pop     = w_valid & mac_ready;
  assign occ_nxt = occ + CNT_W'(push) - CNT_W'(pop);

  assign head      = buf_mem[rd_ptr];
  assign w_valid   = (occ != '0);
  assign w_data    = head.data;
  assign w_last_px = head.last_px;
  assign w_last    = head.last;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    accept     = 1'b0;
    degenerate = 1'b0;
    issue      = 1'b0;
    drain_done = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept = 1'b1;
          // An empty job completes at once and never leaves IDLE.
          if (weight_num == '0 || pixel_num == '0) degenerate = 1'b1;
          else                                     state_nxt  = RUN;
        end
      end
      RUN: begin
        if (gate && credit) begin
          issue = 1'b1;
          if (at_w_end && at_p_end) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        // Look at the next occupancy so that done lands in the cycle
        // right after the final handshake.
        if (inflight == 2'd0 && occ_nxt == '0) begin
          drain_done = 1'b1;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------- datapath
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy          <= 1'b0;
      done          <= 1'b0;
      w_num_q       <= '0;
      p_num_q       <= '0;
      nxt_addr      <= '0;
      px_cnt        <= '0;
      raddra_filter <= '0;
      vld_pipe      <= '0;
      tag_pipe      <= '0;
      buf_mem       <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      occ           <= '0;
    end else begin
      busy <= (state_nxt != IDLE);
      done <= degenerate | drain_done;

      if (accept) begin
        w_num_q  <= weight_num;
        p_num_q  <= pixel_num;
        nxt_addr <= '0;
        px_cnt   <= '0;
      end else if (issue) begin
        raddra_filter <= nxt_addr;
        if (at_w_end) begin
          nxt_addr <= '0;
          px_cnt   <= at_p_end ? '0 : px_cnt + 1'b1;
        end else begin
          nxt_addr <= nxt_addr + 1'b1;
        end
      end

      // The tag travels alongside the read so the flags line up with the data.
      vld_pipe <= {vld_pipe[STAGES-1:0], issue};
      tag_pipe <= {tag_pipe[STAGES-1:0], tag_t'{at_w_end, at_w_end & at_p_end}};

      if (push) begin
        buf_mem[wr_ptr] <= ent_t'{weight_out,
                                  tag_pipe[STAGES].last_px,
                                  tag_pipe[STAGES].last};
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      occ <= occ_nxt;
    end
  end

endmodule
